// File: rtl/tone_pkg.sv
// tone_pkg: shared definitions for the tone_meter peripheral.
//   - Avalon register word addresses
//   - measurement FSM state encoding
//   - STATUS / CTRL bit positions
//   - saturating multiply used to scale the gated edge count to Hz
package tone_pkg;

    typedef enum logic [1:0] {
        REG_FREQ   = 2'd0,
        REG_PERIOD = 2'd1,
        REG_STATUS = 2'd2,
        REG_CTRL   = 2'd3
    } reg_addr_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    localparam int ST_VALID    = 0;
    localparam int ST_TIMEOUT  = 1;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    // n * k clamped to 32 bits.
    function automatic logic [31:0] sat_mul(input logic [32:0] n, input int unsigned k);
        logic [63:0] prod;
        prod = 64'(n) * 64'(k);
        return (|prod[63:32]) ? 32'hFFFF_FFFF : prod[31:0];
    endfunction

endpackage

// File: rtl/tone_edge_det.sv
// tone_edge_det: conditions the asynchronous tone input and emits a
// one-cycle registered pulse on each rising edge.
//   clk, reset : system clock, synchronous active-high reset
//   tone_i     : raw asynchronous square wave
//   rise_o     : 1-cycle rising-edge pulse (3 cycles after the input edge)
// Build option TONE_METER_FILTER_EN inserts a stability filter after the
// synchronizer: the level follows the raw input only once it has differed
// for FILT_LEN consecutive cycles, so shorter pulses are dropped.
module tone_edge_det #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tone_i,
    output logic rise_o
);

    if (FILT_LEN < 1) begin : g_bad_filt_len
        $error("tone_edge_det: FILT_LEN must be at least 1");
    end

    logic sync1_q, sync2_q, prev_q, rise_q;
    logic level;

`ifdef TONE_METER_FILTER_EN
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic          filt_q;
    logic [CW-1:0] stab_q;

    // stab_q counts consecutive cycles where the raw level disagrees with the
    // filtered one; the flip happens on the FILT_LEN-th disagreeing sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= 1'b0;
            stab_q <= '0;
        end else if (sync2_q == filt_q) begin
            stab_q <= '0;
        end else if (stab_q == CW'(FILT_LEN - 1)) begin
            filt_q <= sync2_q;
            stab_q <= '0;
        end else begin
            stab_q <= stab_q + 1'b1;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= tone_i;
            sync2_q <= sync1_q;
            prev_q  <= level;
            rise_q  <= level & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/tone_meter.sv
// tone_meter: Avalon-MM slave that measures a square wave on tone_in.
//   clk, reset            : system clock, synchronous active-high reset
//   tone_in               : asynchronous square-wave input
//   address/read/write    : Avalon word address and strobes
//   writedata / readdata  : Avalon data; readdata is registered, latency 1
//   irq                   : level interrupt = STATUS.valid & CTRL.irq_en
// Registers: 0 FREQ (Hz, RO), 1 PERIOD (cycles, RO),
//            2 STATUS {timeout, valid} W1C, 3 CTRL {irq_en, enable}.
// Build option TONE_METER_FILTER_EN enables the input glitch filter.
module tone_meter
    import tone_pkg::*;
#(
    parameter int unsigned FCLK     = 50_000_000,
    parameter int unsigned GATE_HZ  = 10,
    parameter int unsigned FILT_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tone_in,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int unsigned GATE_CYCLES = FCLK / GATE_HZ;
    localparam logic [31:0] GC          = GATE_CYCLES;

    if (GATE_CYCLES < 2) begin : g_bad_gate
        $error("tone_meter: FCLK/GATE_HZ must be at least 2");
    end

    logic rise;

    tone_edge_det #(.FILT_LEN(FILT_LEN)) u_edge (
        .clk    (clk),
        .reset  (reset),
        .tone_i (tone_in),
        .rise_o (rise)
    );

    state_e      state_q, state_d;
    logic [31:0] gate_q, gate_d;
    logic [31:0] edge_q, edge_d;
    logic [31:0] per_q, per_d;
    logic [31:0] freq_q, freq_d;
    logic [31:0] period_q, period_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  status_q, status_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        wr_status, wr_ctrl;
    logic        set_valid, set_tmo;

    // Only the low two bits of any register are writable.
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:2];

    assign wr_status = write && (reg_addr_e'(address) == REG_STATUS);
    assign wr_ctrl   = write && (reg_addr_e'(address) == REG_CTRL);

    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        edge_d    = edge_q;
        per_d     = per_q;
        freq_d    = freq_q;
        period_d  = period_q;
        set_valid = 1'b0;
        set_tmo   = 1'b0;

        case (state_q)
            IDLE: begin
                gate_d = '0;
                edge_d = '0;
                per_d  = '0;
                if (ctrl_q[CTRL_EN]) state_d = ARM;
            end
            ARM: begin
                if (rise) begin
                    gate_d  = '0;
                    edge_d  = '0;
                    per_d   = 32'd1;
                    state_d = MEASURE;
                end else if (per_q >= GC - 1) begin
                    // A dead input would otherwise sit in ARM forever; report
                    // the timeout and start gating so FREQ settles to 0.
                    per_d    = GC;
                    period_d = '0;
                    set_tmo  = 1'b1;
                    gate_d   = '0;
                    edge_d   = '0;
                    state_d  = MEASURE;
                end else begin
                    per_d = per_q + 32'd1;
                end
            end
            MEASURE: begin
                // Gate window; an edge on the terminal cycle still belongs to it.
                if (gate_q >= GC - 1) begin
                    freq_d    = sat_mul({1'b0, edge_q} + 33'(rise), GATE_HZ);
                    set_valid = 1'b1;
                    gate_d    = '0;
                    edge_d    = '0;
                end else begin
                    gate_d = gate_q + 32'd1;
                    edge_d = edge_q + 32'(rise);
                end
                // Period counter saturates at GC once it times out.
                if (rise) begin
                    period_d = per_q;
                    per_d    = 32'd1;
                end else if (per_q < GC) begin
                    per_d = per_q + 32'd1;
                    if (per_q == GC - 1) begin
                        period_d = '0;
                        set_tmo  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Disabling overrides the state move but the gate result above stands.
        if (wr_ctrl && !writedata[CTRL_EN]) begin
            state_d = IDLE;
            gate_d  = '0;
            edge_d  = '0;
            per_d   = '0;
        end

        // W1C first, hardware sets last so a coincident set wins.
        status_d = status_q & ~(wr_status ? writedata[1:0] : 2'b00);
        if (set_valid) status_d[ST_VALID]   = 1'b1;
        if (set_tmo)   status_d[ST_TIMEOUT] = 1'b1;

        ctrl_d = wr_ctrl ? writedata[1:0] : ctrl_q;

        rdata_d = rdata_q;
        if (read) begin
            case (reg_addr_e'(address))
                REG_FREQ:   rdata_d = freq_q;
                REG_PERIOD: rdata_d = period_q;
                REG_STATUS: rdata_d = {30'd0, status_q};
                REG_CTRL:   rdata_d = {30'd0, ctrl_q};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            gate_q   <= '0;
            edge_q   <= '0;
            per_q    <= '0;
            freq_q   <= '0;
            period_q <= '0;
            rdata_q  <= '0;
            status_q <= '0;
            ctrl_q   <= '0;
        end else begin
            state_q  <= state_d;
            gate_q   <= gate_d;
            edge_q   <= edge_d;
            per_q    <= per_d;
            freq_q   <= freq_d;
            period_q <= period_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = status_q[ST_VALID] & ctrl_q[CTRL_IRQ_EN];

endmodule
